// File: rtl/req_priority_arbiter.sv
// req_priority_arbiter: eight active-low requesters, one shared resource.
// 74x148-style priority pick, registered grant held until owner release or
// hold timeout, followed by one mandatory bus-turnaround cycle.
// Optional macro ARB_ROUND_ROBIN_EN: rotating priority starting below the
// most recent owner; when undefined, fixed priority with bit 7 highest.
module req_priority_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_n,
    input  logic       en_n,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       busy,
    output logic       timeout,
    output logic       any_req_n
);

    localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [7:0]       gnt_nxt;
    logic [2:0]       gnt_id_nxt;
    logic             gnt_valid_nxt;
    logic             busy_nxt;
    logic             timeout_nxt;
    logic             win_found;
    logic [2:0]       win_id;
`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0]       last_id, last_id_nxt;
    logic [2:0]       scan_id;
`endif

    // Group request indication, gated by the enable
    assign any_req_n = en_n | (&req_n);

    // Winner selection; the last match in the scan is the highest priority
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
`ifdef ARB_ROUND_ROBIN_EN
        scan_id   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            scan_id = last_id - 3'(k) - 3'd1;
            if (!req_n[scan_id]) begin
                win_found = 1'b1;
                win_id    = scan_id;
            end
        end
`else
        for (int i = 0; i < 8; i++) begin
            if (!req_n[i]) begin
                win_found = 1'b1;
                win_id    = 3'(i);
            end
        end
`endif
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt     = state;
        hold_cnt_nxt  = hold_cnt;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_id_nxt   = last_id;
`endif
        case (state)
            IDLE: begin
                if (!en_n && win_found) begin
                    state_nxt     = GRANT;
                    gnt_nxt       = 8'd1 << win_id;
                    gnt_id_nxt    = win_id;
                    gnt_valid_nxt = 1'b1;
                    hold_cnt_nxt  = '0;
                end
            end
            GRANT: begin
                // Owner release takes precedence over the timeout
                if (req_n[gnt_id] || (hold_cnt == CNT_LAST)) begin
                    state_nxt     = RELEASE;
                    gnt_nxt       = 8'h00;
                    gnt_valid_nxt = 1'b0;
                    timeout_nxt   = !req_n[gnt_id];
`ifdef ARB_ROUND_ROBIN_EN
                    last_id_nxt   = gnt_id;
`endif
                end else if (hold_cnt != CNT_SAT) begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt     = IDLE;
                gnt_nxt       = 8'h00;
                gnt_valid_nxt = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_id   <= 3'd0;
`endif
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            busy      <= busy_nxt;
            timeout   <= timeout_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            last_id   <= last_id_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_req_priority_arbiter.sv
// Testbench for req_priority_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level owner/hold-time model.
module tb_req_priority_arbiter;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_n;
    logic       en_n;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       busy;
    logic       timeout;
    logic       any_req_n;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 none), cycles it has held the
    // grant, a pending turnaround cycle, last owner, and timeout pulse.
    int m_owner;
    int m_id;
    int m_held;
    int m_last;
    bit m_gap;
    bit m_to;

    always #5 clk = ~clk;

    req_priority_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_n     (req_n),
        .en_n      (en_n),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .busy      (busy),
        .timeout   (timeout),
        .any_req_n (any_req_n)
    );

    function automatic int pick(input logic [7:0] r, input int last);
        int idx;
        if (last < 0) return -1;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++) begin
            idx = (((last - k) % 8) + 8) % 8;
            if (!r[idx]) return idx;
        end
`else
        for (int k = 7; k >= 0; k--) begin
            idx = k;
            if (!r[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    function automatic logic [7:0] exp_gnt();
        if (m_owner < 0) return 8'h00;
        return 8'(1 << m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_id = 0; m_held = 0; m_last = 0; m_gap = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic e);
        m_to = 0;
        if (m_gap) begin
            m_gap = 0;
        end else if (m_owner >= 0) begin
            if (r[m_owner]) begin
                m_last = m_owner; m_owner = -1; m_gap = 1;
            end else if (m_held == int'(MAX_HOLD)) begin
                m_last = m_owner; m_owner = -1; m_gap = 1; m_to = 1;
            end else begin
                m_held++;
            end
        end else if (!e && r != 8'hFF) begin
            m_owner = pick(r, m_last); m_id = m_owner; m_held = 1;
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, settle 1ns
    task automatic cycle(input logic [7:0] r, input logic e);
        req_n = r;
        en_n  = e;
        @(posedge clk);
        model_step(r, e);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_n = 8'h00; en_n = 1'b1; rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%h valid=%b busy=%b to=%b id=%0d, need all zero", gnt, gnt_valid, busy, timeout, gnt_id);
        end
        checks++;
        if (any_req_n !== 1'b1) begin
            errors++; $display("FAIL reset_any_req_en_high: got %b need 1", any_req_n);
        end
        en_n = 1'b0; #1;
        checks++;
        if (any_req_n !== 1'b0) begin
            errors++; $display("FAIL reset_any_req_en_low: got %b need 0", any_req_n);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_priority();
        do_reset();
        cycle(8'b1101_0111, 1'b0);
        checks++;
        if (gnt !== 8'h20 || gnt_id !== 3'd5 || gnt_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL prio_first: gnt=%h id=%0d valid=%b busy=%b need 20/5/1/1", gnt, gnt_id, gnt_valid, busy);
        end
        cycle(8'b1111_0111, 1'b0);
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
            errors++; $display("FAIL prio_release: gnt=%h valid=%b busy=%b to=%b need 00/0/1/0", gnt, gnt_valid, busy, timeout);
        end
        cycle(8'b1111_0111, 1'b0);
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0 || gnt_id !== 3'd5) begin
            errors++; $display("FAIL prio_idle: gnt=%h busy=%b id=%0d need 00/0/5", gnt, busy, gnt_id);
        end
        cycle(8'b1111_0111, 1'b0);
        checks++;
        if (gnt !== 8'h08 || gnt_id !== 3'd3 || gnt_id !== 3'(m_id)) begin
            errors++; $display("FAIL prio_second: gnt=%h id=%0d need 08/3", gnt, gnt_id);
        end
    endtask

    task automatic test_timeout();
        int high_cycles;
        bit saw_to;
        do_reset();
        high_cycles = 0;
        saw_to = 0;
        cycle(8'hFE, 1'b0);
        while (gnt === 8'h01 && high_cycles < 20) begin
            high_cycles++;
            cycle(8'hFE, 1'b0);
        end
        checks++;
        if (high_cycles != int'(MAX_HOLD)) begin
            errors++; $display("FAIL timeout_duration: held %0d cycles need %0d", high_cycles, MAX_HOLD);
        end
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_pulse: gnt=%h to=%b busy=%b need 00/1/1", gnt, timeout, busy);
        end
        cycle(8'hFE, 1'b0);
        checks++;
        if (timeout !== 1'b0 || gnt !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_one_cycle: to=%b gnt=%h busy=%b need 0/00/0", timeout, gnt, busy);
        end
        cycle(8'hFE, 1'b0);
        checks++;
        if (gnt !== 8'h01 || gnt_id !== 3'd0 || gnt_valid !== 1'b1) begin
            errors++; $display("FAIL timeout_regrant: gnt=%h id=%0d valid=%b need 01/0/1", gnt, gnt_id, gnt_valid);
        end
    endtask

    task automatic test_release_at_limit();
        do_reset();
        cycle(8'hBF, 1'b0);
        while (m_held < int'(MAX_HOLD)) cycle(8'hBF, 1'b0);
        cycle(8'hFF, 1'b0);
        checks++;
        if (timeout !== 1'b0 || gnt !== 8'h00 || busy !== 1'b1) begin
            errors++; $display("FAIL release_at_limit: to=%b gnt=%h busy=%b need 0/00/1", timeout, gnt, busy);
        end
    endtask

    task automatic test_enable();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(8'h00, 1'b1);
            checks++;
            if (gnt !== 8'h00 || any_req_n !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL enable_blocked: gnt=%h any=%b busy=%b need 00/1/0", gnt, any_req_n, busy);
            end
        end
        cycle(8'h00, 1'b0);
        checks++;
        if (gnt !== 8'h80 || gnt_id !== 3'd7) begin
            errors++; $display("FAIL enable_grant: gnt=%h id=%0d need 80/7", gnt, gnt_id);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(8'h00, 1'b1);
            checks++;
            if (gnt !== 8'h80 || gnt_valid !== 1'b1 || any_req_n !== 1'b1) begin
                errors++; $display("FAIL enable_persist: gnt=%h valid=%b any=%b need 80/1/1", gnt, gnt_valid, any_req_n);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(8'h80, 1'b1);
            checks++;
            if (gnt !== exp_gnt() || busy !== (m_owner >= 0 || m_gap)) begin
                errors++; $display("FAIL enable_after_release: gnt=%h busy=%b need %h/%b", gnt, busy, exp_gnt(), (m_owner >= 0 || m_gap));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(8'h00, 1'b0);
        cycle(8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
            errors++; $display("FAIL async_reset: gnt=%h busy=%b valid=%b id=%0d need 00/0/0/0", gnt, busy, gnt_valid, gnt_id);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_rotation();
        int ids[3];
        int n;
        logic prev_valid;
        do_reset();
        n = 0;
        prev_valid = 1'b0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            cycle(8'h00, 1'b0);
            if (gnt_valid === 1'b1 && prev_valid !== 1'b1) begin
                ids[n] = int'(gnt_id);
                n++;
            end
            prev_valid = gnt_valid;
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL rotation_count: saw %0d grants need 3", n);
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            checks++;
            if (ids[0] != 7 || ids[1] != 6 || ids[2] != 5) begin
                errors++; $display("FAIL rotation_ids: got %0d,%0d,%0d need 7,6,5", ids[0], ids[1], ids[2]);
            end
`else
            checks++;
            if (ids[0] != 7 || ids[1] != 7 || ids[2] != 7) begin
                errors++; $display("FAIL rotation_ids: got %0d,%0d,%0d need 7,7,7", ids[0], ids[1], ids[2]);
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic e;
        do_reset();
        r = 8'hFF;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = 8'hFF;
            e = ($urandom_range(0, 4) == 0);
            cycle(r, e);
            checks++;
            if (gnt !== exp_gnt() || gnt_valid !== (m_owner >= 0) || busy !== (m_owner >= 0 || m_gap)
                || timeout !== m_to || gnt_id !== 3'(m_id) || any_req_n !== (e | (r == 8'hFF))) begin
                errors++;
                $display("FAIL random_cycle%0d: gnt=%h id=%0d v=%b busy=%b to=%b any=%b need %h/%0d/%b/%b/%b/%b",
                         c, gnt, gnt_id, gnt_valid, busy, timeout, any_req_n,
                         exp_gnt(), m_id, (m_owner >= 0), (m_owner >= 0 || m_gap), m_to, (e | (r == 8'hFF)));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_n = 8'hFF;
        en_n  = 1'b1;
        model_reset();
        test_reset();
        test_priority();
        test_timeout();
        test_release_at_limit();
        test_enable();
        test_async_reset();
        test_rotation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
